adc_pkt_rx: RTL and testbench

- Receive-side counterpart of the ADC capture packet controller; sits on the capture-board/bench side of the ADC_DATA pads.
- Samples the 18-bit ADC_DATA bus and ADC_DATA_VALID, each synchronous to CLK_RD.
- Delineates packets as contiguous valid runs and emits them as a sop/eop-framed word stream.
- Checks each packet's length against the configured type (216/432/864/1728 words) and the inter-packet gap against the configured minimum, and keeps packet and error counters.

---
 rtl/adc_pkt_pkg.sv | 22 ++
 rtl/adc_pkt_rx_hold.sv | 57 +++++
 rtl/adc_pkt_rx.sv | 144 ++++++++++++++
 tb/tb_adc_pkt_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkt_pkg.sv
// adc_pkt_pkg: shared types and constants for the ADC packet receiver.
//   state_t      - receiver FSM states
//   PKT_LEN_BASE - length of the smallest packet type, in words
//   pkt_len()    - expected words for a 2-bit packet type (216 << type)
package adc_pkt_pkg;

    localparam int DATA_W       = 18;
    localparam int CNT_W        = 11;
    localparam int PKT_LEN_BASE = 216;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        SYNC     = 2'd1,
        IDLE     = 2'd2,
        RECV     = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] pkt_len(input logic [1:0] pkt_type);
        return CNT_W'(PKT_LEN_BASE) << pkt_type;
    endfunction

endpackage

// File: rtl/adc_pkt_rx_hold.sv
// adc_pkt_rx_hold: one-word hold stage that frames accepted words.
// A word accepted on one edge sits in the hold register for one cycle so
// the following cycle's valid decides whether it is the last of its run.
//   clk, rst          - clock, synchronous active-high reset
//   flush             - drop the held word without emitting it
//   in_vld/in_first   - accepted word strobe and first-of-run flag
//   in_data           - accepted word
//   rx_data/rx_valid/rx_sop/rx_eop - registered framed output
//   sop_next/eop_next - what rx_sop/rx_eop will be after this edge
module adc_pkt_rx_hold #(
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_vld,
    input  logic              in_first,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_sop,
    output logic              rx_eop,
    output logic              sop_next,
    output logic              eop_next
);

    logic              hold_vld;
    logic              hold_first;
    logic [DATA_W-1:0] hold_data;
    logic              emit;

    assign emit     = hold_vld && !flush;
    assign sop_next = emit && hold_first;
    // No word follows the held one: it closes the run.
    assign eop_next = emit && !in_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld   <= 1'b0;
            hold_first <= 1'b0;
            hold_data  <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_sop     <= 1'b0;
            rx_eop     <= 1'b0;
        end else begin
            hold_vld   <= in_vld && !flush;
            hold_first <= in_vld && in_first;
            hold_data  <= in_vld ? in_data : '0;
            rx_valid   <= emit;
            rx_data    <= emit ? hold_data : '0;
            rx_sop     <= sop_next;
            rx_eop     <= eop_next;
        end
    end

endmodule

// File: rtl/adc_pkt_rx.sv
// adc_pkt_rx: receive side of the ADC capture packet link.
// Delineates contiguous ADC_DATA_VALID runs into sop/eop framed packets,
// checks run length against the configured type and the preceding idle
// gap against cfg_gap, and counts packets and errors.
//   clk, rst                 - CLK_RD clock, synchronous active-high reset
//   cfg_en                   - receiver enable
//   cfg_data_length          - packet type (216 << type words)
//   cfg_gap                  - minimum idle cycles between packets (0 = off)
//   adc_data, adc_data_valid - pad inputs
//   rx_*                     - framed output stream and error/abort pulses
//   pkt_cnt                  - wrapping count of emitted eops
//   err_cnt                  - saturating count of len/gap errors
//   busy                     - receiving a packet
module adc_pkt_rx
    import adc_pkt_pkg::*;
#(
    parameter int DATA_W    = adc_pkt_pkg::DATA_W,
    parameter int CNT_W     = adc_pkt_pkg::CNT_W,
    parameter int PKT_CNT_W = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_en,
    input  logic [1:0]           cfg_data_length,
    input  logic [7:0]           cfg_gap,
    input  logic [DATA_W-1:0]    adc_data,
    input  logic                 adc_data_valid,
    output logic [DATA_W-1:0]    rx_data,
    output logic                 rx_valid,
    output logic                 rx_sop,
    output logic                 rx_eop,
    output logic                 rx_len_err,
    output logic                 rx_gap_err,
    output logic                 rx_abort,
    output logic [PKT_CNT_W-1:0] pkt_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);

    state_t             state;
    logic [7:0]         idle_cnt;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   exp_len;
    logic               gap_err_q;
    logic               exempt;

    logic               in_vld;
    logic               in_first;
    logic               sop_next;
    logic               eop_next;
    logic               len_err_next;
    logic               gap_err_next;
    logic               abort_next;
    logic [ERR_CNT_W:0] err_sum;
    logic [ERR_CNT_W-1:0] err_next;

    // Words are only accepted once synced to a run boundary.
    assign in_vld   = cfg_en && adc_data_valid && (state == IDLE || state == RECV);
    assign in_first = (state == IDLE);

    adc_pkt_rx_hold #(.DATA_W(DATA_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .flush    (!cfg_en),
        .in_vld   (in_vld),
        .in_first (in_first),
        .in_data  (adc_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_sop   (rx_sop),
        .rx_eop   (rx_eop),
        .sop_next (sop_next),
        .eop_next (eop_next)
    );

    // A saturated word_cnt (all ones) never equals a legal length, so
    // overlong runs fall out as length errors.
    assign len_err_next = eop_next && (word_cnt != exp_len);
    assign gap_err_next = sop_next && gap_err_q;
    assign abort_next   = (state == RECV) && !cfg_en;

    // A 1-word packet can raise both flags at once, hence the +2 case.
    assign err_sum  = {1'b0, err_cnt} + (ERR_CNT_W+1)'(len_err_next)
                                      + (ERR_CNT_W+1)'(gap_err_next);
    assign err_next = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];

    assign busy = (state == RECV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DISABLED;
            idle_cnt   <= '0;
            word_cnt   <= '0;
            exp_len    <= '0;
            gap_err_q  <= 1'b0;
            exempt     <= 1'b0;
            rx_len_err <= 1'b0;
            rx_gap_err <= 1'b0;
            rx_abort   <= 1'b0;
            pkt_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            rx_len_err <= len_err_next;
            rx_gap_err <= gap_err_next;
            rx_abort   <= abort_next;
            err_cnt    <= err_next;
            if (eop_next)
                pkt_cnt <= pkt_cnt + 1'b1;

            if (!cfg_en) begin
                state <= DISABLED;
            end else begin
                case (state)
                    DISABLED: state <= SYNC;
                    // Skip whatever run was in flight when enabled.
                    SYNC: if (!adc_data_valid) begin
                        state    <= IDLE;
                        idle_cnt <= 8'd1;
                        exempt   <= 1'b1;
                    end
                    IDLE: if (adc_data_valid) begin
                        state     <= RECV;
                        word_cnt  <= CNT_W'(1);
                        exp_len   <= CNT_W'(pkt_len(cfg_data_length));
                        gap_err_q <= !exempt && (cfg_gap != 8'd0) && (idle_cnt < cfg_gap);
                        exempt    <= 1'b0;
                    end else if (idle_cnt != 8'hFF) begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                    RECV: if (adc_data_valid) begin
                        if (word_cnt != '1)
                            word_cnt <= word_cnt + 1'b1;
                    end else begin
                        state    <= IDLE;
                        idle_cnt <= 8'd1;
                    end
                    default: state <= DISABLED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_pkt_rx.sv
// tb_adc_pkt_rx: directed bench for adc_pkt_rx. A run-level reference model
// predicts every output each cycle; literal checks pin key results per test.
module tb_adc_pkt_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_en = 1'b0;
    logic [1:0]  cfg_data_length = 2'd0;
    logic [7:0]  cfg_gap = 8'd0;
    logic [17:0] adc_data = '0;
    logic        adc_data_valid = 1'b0;
    logic [17:0] rx_data;
    logic        rx_valid, rx_sop, rx_eop, rx_len_err, rx_gap_err, rx_abort, busy;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;

    adc_pkt_rx dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_data_length(cfg_data_length),
        .cfg_gap(cfg_gap), .adc_data(adc_data), .adc_data_valid(adc_data_valid),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_len_err(rx_len_err), .rx_gap_err(rx_gap_err), .rx_abort(rx_abort),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Expected outputs after the coming edge.
    logic [17:0] e_data;
    logic e_valid, e_sop, e_eop, e_len, e_gap, e_abort, e_busy;
    int   e_pkt, e_err;

    // Model state, unbounded integers where the DUT saturates.
    int   phase = 0;         // 0 off, 1 waiting for a gap to sync, 2 active
    bit   inrun = 0;
    bit   exempt = 0;
    int   idle_n = 0;
    int   run_len = 0;
    int   exp_n = 0;
    bit   run_gap_bad = 0;
    logic [17:0] held = '0;
    bit   held_first = 0;
    int   pkts = 0;
    int   errs = 0;

    // Observed-event statistics for literal checks.
    int n_valid = 0, n_sop = 0, n_eop = 0, n_abort = 0, n_gap = 0, n_len = 0;
    int n_both = 0, n_sopeop = 0, sop_cyc = 0;
    logic [17:0] last_sop_data = '0, last_eop_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        e_valid = 0; e_data = '0; e_sop = 0; e_eop = 0;
        e_len = 0; e_gap = 0; e_abort = 0;
        if (rst) begin
            phase = 0; inrun = 0; pkts = 0; errs = 0;
        end else if (!cfg_en) begin
            e_abort = inrun;
            inrun = 0;
            phase = 0;
        end else if (phase == 0) begin
            phase = 1;
        end else if (phase == 1) begin
            if (!adc_data_valid) begin
                phase = 2; idle_n = 1; exempt = 1;
            end
        end else if (inrun) begin
            e_valid = 1;
            e_data  = held;
            e_sop   = held_first;
            e_gap   = held_first && run_gap_bad;
            if (adc_data_valid) begin
                held = adc_data; held_first = 0; run_len++;
            end else begin
                e_eop = 1;
                e_len = (run_len != exp_n);
                inrun = 0;
                idle_n = 1;
            end
        end else if (adc_data_valid) begin
            inrun = 1; held = adc_data; held_first = 1; run_len = 1;
            exp_n = 216 * (1 << cfg_data_length);
            run_gap_bad = !exempt && cfg_gap != 0 && idle_n < int'(cfg_gap);
            exempt = 0;
        end else begin
            idle_n++;
        end
        if (e_eop) pkts = (pkts + 1) % 65536;
        errs = errs + int'(e_len) + int'(e_gap);
        if (errs > 255) errs = 255;
        e_busy = inrun;
        e_pkt = pkts;
        e_err = errs;
    endtask

    task automatic compare_all();
        chk("rx_valid", 32'(rx_valid), 32'(e_valid));
        chk("rx_data", 32'(rx_data), 32'(e_data));
        chk("rx_sop", 32'(rx_sop), 32'(e_sop));
        chk("rx_eop", 32'(rx_eop), 32'(e_eop));
        chk("rx_len_err", 32'(rx_len_err), 32'(e_len));
        chk("rx_gap_err", 32'(rx_gap_err), 32'(e_gap));
        chk("rx_abort", 32'(rx_abort), 32'(e_abort));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("pkt_cnt", 32'(pkt_cnt), 32'(e_pkt));
        chk("err_cnt", 32'(err_cnt), 32'(e_err));
        if (rx_valid) n_valid++;
        if (rx_sop) begin n_sop++; last_sop_data = rx_data; sop_cyc = cyc; end
        if (rx_eop) begin n_eop++; last_eop_data = rx_data; end
        if (rx_abort) n_abort++;
        if (rx_gap_err) n_gap++;
        if (rx_len_err) n_len++;
        if (rx_gap_err && rx_len_err) n_both++;
        if (rx_sop && rx_eop) n_sopeop++;
    endtask

    // One clock: drive inputs, predict, let the edge pass, compare.
    task automatic step(input logic en, input logic v, input logic [17:0] d);
        cfg_en = en;
        adc_data_valid = v;
        adc_data = v ? d : '0;
        model_step();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
    endtask

    task automatic run(input int n, input int base);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 18'(base + i));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        rst = 1'b0;
    endtask

    int b_valid, b_gap, b_len, b_abort, b_eop, b_both, b_sopeop, sample_cyc;

    task automatic snap();
        b_valid = n_valid; b_gap = n_gap; b_len = n_len; b_abort = n_abort;
        b_eop = n_eop; b_both = n_both; b_sopeop = n_sopeop;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("reset rx_valid", 32'(rx_valid), 0);
        chk("reset pkt_cnt", 32'(pkt_cnt), 0);
        chk("reset busy", 32'(busy), 0);

        // T1: clean 216-word packet, 1-cycle latency
        cfg_data_length = 2'd0; cfg_gap = 8'd4;
        snap();
        idle(3);
        sample_cyc = cyc + 1;
        run(216, 0);
        idle(10);
        chk("t1 latency", 32'(sop_cyc - sample_cyc), 1);
        chk("t1 sop data", 32'(last_sop_data), 0);
        chk("t1 eop data", 32'(last_eop_data), 215);
        chk("t1 words", 32'(n_valid - b_valid), 216);
        chk("t1 pkt_cnt", 32'(pkt_cnt), 1);
        chk("t1 err_cnt", 32'(err_cnt), 0);

        // T2: two 1728-word packets, 2-cycle gap < 4
        do_reset();
        cfg_data_length = 2'd3; cfg_gap = 8'd4;
        snap();
        idle(3);
        run(1728, 0);
        idle(2);
        run(1728, 5000);
        idle(5);
        chk("t2 gap errs", 32'(n_gap - b_gap), 1);
        chk("t2 pkt_cnt", 32'(pkt_cnt), 2);
        chk("t2 err_cnt", 32'(err_cnt), 1);

        // T3: short and long runs against a 432 type
        do_reset();
        cfg_data_length = 2'd1; cfg_gap = 8'd4;
        snap();
        idle(3);
        run(400, 0);
        idle(8);
        run(500, 1000);
        idle(5);
        chk("t3 len errs", 32'(n_len - b_len), 2);
        chk("t3 gap errs", 32'(n_gap - b_gap), 0);
        chk("t3 err_cnt", 32'(err_cnt), 2);

        // T4: enable mid-run discards that run; next packet gap-exempt
        do_reset();
        cfg_data_length = 2'd0; cfg_gap = 8'd200;
        snap();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 18'(i));
        run(40, 10);
        idle(5);
        run(216, 300);
        idle(5);
        chk("t4 words", 32'(n_valid - b_valid), 216);
        chk("t4 sop data", 32'(last_sop_data), 300);
        chk("t4 pkt_cnt", 32'(pkt_cnt), 1);
        chk("t4 err_cnt", 32'(err_cnt), 0);

        // T5: disable at word 100, then reset mid-packet
        do_reset();
        cfg_data_length = 2'd0; cfg_gap = 8'd4;
        idle(3);
        run(216, 0);
        idle(5);
        snap();
        run(100, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 18'(100 + i));
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("t5 aborts", 32'(n_abort - b_abort), 1);
        chk("t5 eops", 32'(n_eop - b_eop), 0);
        chk("t5 pkt_cnt", 32'(pkt_cnt), 1);
        idle(3);
        run(30, 0);
        chk("t5 busy pre-rst", 32'(busy), 1);
        rst = 1'b1;
        step(1'b1, 1'b1, 18'd30);
        rst = 1'b0;
        chk("t5 rst rx_valid", 32'(rx_valid), 0);
        chk("t5 rst busy", 32'(busy), 0);
        chk("t5 rst pkt_cnt", 32'(pkt_cnt), 0);
        idle(4);

        // T6: single-word packet, gap check off
        do_reset();
        cfg_data_length = 2'd0; cfg_gap = 8'd0;
        snap();
        idle(3);
        step(1'b1, 1'b1, 18'd42);
        idle(5);
        chk("t6 sop=eop", 32'(n_sopeop - b_sopeop), 1);
        chk("t6 eop data", 32'(last_eop_data), 42);
        chk("t6 len errs", 32'(n_len - b_len), 1);
        chk("t6 err_cnt", 32'(err_cnt), 1);

        // T7: 1-word packets with short gaps, double errors, saturation
        do_reset();
        cfg_data_length = 2'd0; cfg_gap = 8'd4;
        snap();
        idle(3);
        for (int i = 0; i < 130; i++) begin
            step(1'b1, 1'b1, 18'(i));
            step(1'b1, 1'b0, '0);
        end
        idle(3);
        chk("t7 both flags", 32'(n_both - b_both > 0), 1);
        chk("t7 err_cnt sat", 32'(err_cnt), 255);
        chk("t7 pkt_cnt", 32'(pkt_cnt), 130);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
